// File: rtl/scnn_decompress_ips_pkg.sv
`default_nettype none
// ============================================================================
// scnn_pkg : shared types and constants for the SCNN activation decompressor
// Revision : 1.0
// ============================================================================
package scnn_pkg;

  localparam int unsigned SCNN_N  = 16;
  localparam int unsigned SCNN_DW = 16;
  localparam int unsigned SCNN_IW = 5;
  localparam int unsigned SCNN_CW = 5;
  localparam int unsigned SCNN_AW = $clog2(SCNN_N);

  typedef logic [SCNN_DW-1:0] act_t;
  typedef logic [SCNN_IW-1:0] idx_t;
  typedef logic [SCNN_CW-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } dec_state_e;

  // Requests for more pairs than there are dense slots are clamped.
  function automatic cnt_t sat_count(input cnt_t n);
    return (n > cnt_t'(SCNN_N)) ? cnt_t'(SCNN_N) : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scnn_decompress_ips_if.sv
`default_nettype none
// ============================================================================
// scnn_decompress_ips_if : compressed-pair input and dense-array output bus
// Revision : 1.0
// ============================================================================
interface scnn_decompress_ips_if;
  import scnn_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  act_t                       in_data;
  idx_t                       in_idx;
  logic [SCNN_N*SCNN_DW-1:0]  dense_out;
  logic                       out_valid;
  logic                       out_ready;

  modport slave (
    input  in_valid, in_data, in_idx, out_ready,
    output in_ready, dense_out, out_valid
  );

  modport master (
    output in_valid, in_data, in_idx, out_ready,
    input  in_ready, dense_out, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/scnn_decompress_ips.sv
`default_nettype none
// ============================================================================
// scnn_decompress_ips : scatters (value, index) pairs into a zero-filled
//                       16-entry dense buffer and presents it on valid/ready
// Revision : 1.0
// ============================================================================
module scnn_decompress_ips
  import scnn_pkg::*;
(
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  start,
  input  wire cnt_t                  num_nz,
  output logic                       busy,
  output logic                       err_idx,
  scnn_decompress_ips_if.slave       bus
);

  dec_state_e state_q, state_d;
  act_t       buf_q [SCNN_N];
  cnt_t       count_q;
  cnt_t       nz_q;
  logic       err_q;

  logic in_hs;
  logic idx_ok;
  logic last_pair;

  assign in_hs     = bus.in_valid && (state_q == LOAD);
  assign idx_ok    = bus.in_idx < idx_t'(SCNN_N);
  assign last_pair = (count_q == nz_q - cnt_t'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_nz == '0) ? DONE : LOAD;
      LOAD:    if (in_hs && last_pair) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SCNN_N; i++) buf_q[i] <= '0;
      count_q <= '0;
      nz_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < SCNN_N; i++) buf_q[i] <= '0;
            count_q <= '0;
            nz_q    <= sat_count(num_nz);
            err_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (in_hs) begin
            // Out-of-range indices are dropped but still consume a pair slot.
            if (idx_ok) buf_q[bus.in_idx[SCNN_AW-1:0]] <= bus.in_data;
            else        err_q <= 1'b1;
            count_q <= count_q + cnt_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.dense_out = '0;
    for (int i = 0; i < SCNN_N; i++) bus.dense_out[i*SCNN_DW +: SCNN_DW] = buf_q[i];
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign err_idx       = err_q;

endmodule
`default_nettype wire
